// File: rtl/lstm_fwd_seq.sv
// Forward-propagation sequencer for one LSTM gate: runs MAC dot products per cell/timestep, drains, writes.
// Optional performance counters (stall_cnt, cyc_cnt) are enabled with `define LSTM_FWD_SEQ_PERF_EN.
module lstm_fwd_seq #(
    parameter int ADDR_WIDTH = 12,
    parameter int NUM_CELL   = 8,
    parameter int NUM_INPUT  = 53,
    parameter int TIMESTEP   = 7,
    parameter int DELAY      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  stall,
    output logic                  mac_clr,
    output logic                  mac_en,
    output logic                  rec_sel,
    output logic                  rec_zero,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic                  busy,
    output logic                  done
`ifdef LSTM_FWD_SEQ_PERF_EN
    ,
    output logic [31:0]           stall_cnt,
    output logic [31:0]           cyc_cnt
`endif
);
    localparam int K          = NUM_INPUT + NUM_CELL;
    localparam int KW         = $clog2(K);
    localparam int CW         = (NUM_CELL > 1) ? $clog2(NUM_CELL) : 1;
    localparam int TW         = (TIMESTEP > 1) ? $clog2(TIMESTEP) : 1;
    localparam int DW         = (DELAY > 1) ? $clog2(DELAY) : 1;
    localparam int DRAIN_LAST = (DELAY > 0) ? DELAY - 1 : 0;
    localparam logic SKIP_DRAIN = (DELAY == 0);

    // Address arithmetic is done at ADDR_WIDTH, so the address spaces must fit.
    if ((64'(NUM_CELL) * 64'(K) > (64'd1 << ADDR_WIDTH)) ||
        (64'(TIMESTEP) * 64'(NUM_INPUT) > (64'd1 << ADDR_WIDTH))) begin : g_param_check
        $error("lstm_fwd_seq: address space exceeds ADDR_WIDTH");
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_MAC   = 3'd2,
        S_DRAIN = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [CW-1:0]   cell_q, cell_d;
    logic [TW-1:0]   t_q, t_d;
    logic [DW-1:0]   drain_q, drain_d;

    logic [ADDR_WIDTH-1:0] k_a, c_a, t_a;
    assign k_a = ADDR_WIDTH'(k_q);
    assign c_a = ADDR_WIDTH'(cell_q);
    assign t_a = ADDR_WIDTH'(t_q);

    // State and counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            cell_q  <= '0;
            t_q     <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            cell_q  <= cell_d;
            t_q     <= t_d;
            drain_q <= drain_d;
        end
    end

    // Next-state, counter update and combinational outputs
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        cell_d   = cell_q;
        t_d      = t_q;
        drain_d  = drain_q;
        mac_clr  = 1'b0;
        mac_en   = 1'b0;
        rec_sel  = 1'b0;
        rec_zero = 1'b0;
        rd_addr  = {ADDR_WIDTH{1'b0}};
        w_addr   = {ADDR_WIDTH{1'b0}};
        wr_en    = 1'b0;
        wr_addr  = {ADDR_WIDTH{1'b0}};
        busy     = (state_q != S_IDLE);
        done     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                mac_clr = 1'b1;
                k_d     = '0;
                state_d = S_MAC;
            end
            S_MAC: begin
                w_addr = c_a * ADDR_WIDTH'(K) + k_a;
                if (k_q < KW'(NUM_INPUT)) begin
                    rd_addr = t_a * ADDR_WIDTH'(NUM_INPUT) + k_a;
                end else begin
                    rec_sel = 1'b1;
                    if (t_q == '0) begin
                        rec_zero = 1'b1;
                    end else begin
                        rd_addr = (t_a - ADDR_WIDTH'(1)) * ADDR_WIDTH'(NUM_CELL)
                                  + (k_a - ADDR_WIDTH'(NUM_INPUT));
                    end
                end
                if (!stall) begin
                    mac_en = 1'b1;
                    if (k_q == KW'(K - 1)) begin
                        k_d     = '0;
                        drain_d = '0;
                        state_d = SKIP_DRAIN ? S_WRITE : S_DRAIN;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end else begin
                    state_d = S_MAC;
                end
            end
            S_DRAIN: begin
                if (drain_q == DW'(DRAIN_LAST)) begin
                    state_d = S_WRITE;
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            S_WRITE: begin
                wr_en   = 1'b1;
                wr_addr = t_a * ADDR_WIDTH'(NUM_CELL) + c_a;
                if (cell_q == CW'(NUM_CELL - 1)) begin
                    if (t_q == TW'(TIMESTEP - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        cell_d  = '0;
                        t_d     = t_q + TW'(1);
                        state_d = S_LOAD;
                    end
                end else begin
                    cell_d  = cell_q + CW'(1);
                    state_d = S_LOAD;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                k_d     = '0;
                cell_d  = '0;
                t_d     = '0;
                drain_d = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort wins over every other transition and suppresses any pending write/done.
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            k_d     = '0;
            cell_d  = '0;
            t_d     = '0;
            drain_d = '0;
            wr_en   = 1'b0;
            done    = 1'b0;
        end else begin
            state_d = state_d;
        end
    end

`ifdef LSTM_FWD_SEQ_PERF_EN
    logic [31:0] stall_cnt_q, cyc_cnt_q;

    // Saturating busy-cycle and MAC-stall counters, cleared on start acceptance
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= 32'd0;
            cyc_cnt_q   <= 32'd0;
        end else if ((state_q == S_IDLE) && start) begin
            stall_cnt_q <= 32'd0;
            cyc_cnt_q   <= 32'd0;
        end else begin
            if (busy && (cyc_cnt_q != {32{1'b1}})) begin
                cyc_cnt_q <= cyc_cnt_q + 32'd1;
            end else begin
                cyc_cnt_q <= cyc_cnt_q;
            end
            if ((state_q == S_MAC) && stall && (stall_cnt_q != {32{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end else begin
                stall_cnt_q <= stall_cnt_q;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign cyc_cnt   = cyc_cnt_q;
`endif

endmodule
